// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 brute-force key collector.
package rc4_pkg;

    localparam int KEY_W_DEF     = 22;
    localparam int KEY_MAX_W     = 64;
    localparam int KEY_BUS_MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        FAILED = 2'd3
    } state_t;

    // Core index width; a single-core build still needs one bit of index.
    function automatic int idx_width(input int log2_count);
        return (log2_count < 1) ? 1 : log2_count;
    endfunction

    // Extract core idx's key from the packed key bus (core i at [i*key_w +: key_w]).
    // The bus is zero-extended to KEY_BUS_MAX_W by the caller; key_w up to KEY_MAX_W.
    function automatic logic [KEY_MAX_W-1:0] key_slice(
        input logic [KEY_BUS_MAX_W-1:0] keys,
        input int                       idx,
        input int                       key_w
    );
        logic [KEY_BUS_MAX_W-1:0] shifted;
        shifted = keys >> (idx * key_w);
        return shifted[KEY_MAX_W-1:0] & ((KEY_MAX_W'(1) << key_w) - KEY_MAX_W'(1));
    endfunction

endpackage

// File: rtl/rc4_key_collector_if.sv
// Handshake bundle between the cracking cores and the key collector.
interface rc4_key_collector_if #(
    parameter int CORE_COUNT = 2,
    parameter int KEY_W      = rc4_pkg::KEY_W_DEF
);
    logic [CORE_COUNT*KEY_W-1:0] core_key;
    logic [CORE_COUNT-1:0]       core_found;
    logic [CORE_COUNT-1:0]       core_exhausted;
    logic                        stop_all;

    // Cores drive their status and obey the stop broadcast.
    modport master (
        output core_key, core_found, core_exhausted,
        input  stop_all
    );

    // The collector consumes core status and issues the stop broadcast.
    modport slave (
        input  core_key, core_found, core_exhausted,
        output stop_all
    );
endinterface

// File: rtl/rc4_prio_enc.sv
// Lowest-index-wins priority encoder over the per-core request vector.
module rc4_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest asserted request is written last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_collector.sv
// Collects found/exhausted reports from the RC4 cracking cores, latches one winner,
// broadcasts stop_all and counts the clock cycles spent searching.
module rc4_key_collector
    import rc4_pkg::*;
#(
    parameter  int CORE_COUNT_LOG_2 = 1,
    parameter  int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2,
    parameter  int KEY_W            = KEY_W_DEF,
    parameter  int CYC_W            = 32,
    localparam int IDX_W            = idx_width(CORE_COUNT_LOG_2)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    rc4_key_collector_if.slave   cores,
    output logic                 busy,
    output logic                 found,
    output logic                 failed,
    output logic [KEY_W-1:0]     winner_key,
    output logic [IDX_W-1:0]     winner_core,
    output logic [CYC_W-1:0]     search_cycles
);

    state_t                state_q;
    state_t                state_d;
    logic                  start_q;
    logic                  start_armed;
    logic                  start_rise;
    logic [CORE_COUNT-1:0] exh_mask;
    logic [CORE_COUNT-1:0] exh_all;
    logic [IDX_W-1:0]      hit_idx;
    logic                  hit_any;
    logic                  enter_search;
    logic                  take_found;
    logic                  take_failed;

    rc4_prio_enc #(
        .N     (CORE_COUNT),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (cores.core_found),
        .idx (hit_idx),
        .any (hit_any)
    );

    // A start level held high through reset is not a request: start must be seen
    // low at least once after reset before a rising edge can be recognised.
    assign start_rise = start & ~start_q & start_armed;
    assign exh_all    = exh_mask | cores.core_exhausted;

    assign busy           = (state_q == SEARCH);
    assign cores.stop_all = (state_q == FOUND) || (state_q == FAILED);

    // State register plus start edge-detect history.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            start_armed <= start_armed | ~start;
        end
    end

    // Next-state decode; found takes priority over the final exhaustion.
    always_comb begin
        state_d      = state_q;
        enter_search = 1'b0;
        take_found   = 1'b0;
        take_failed  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d      = SEARCH;
                    enter_search = 1'b1;
                end
            end
            SEARCH: begin
                if (hit_any) begin
                    state_d    = FOUND;
                    take_found = 1'b1;
                end else if (&exh_all) begin
                    state_d     = FAILED;
                    take_failed = 1'b1;
                end
            end
            FOUND, FAILED: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers, exhausted mask and saturating cycle counter.
    always_ff @(posedge clk) begin
        // NOTE: these are plain flops, not a memory array, so all of them take the reset value.
        if (!reset_n) begin
            found         <= 1'b0;
            failed        <= 1'b0;
            winner_key    <= '0;
            winner_core   <= '0;
            search_cycles <= '0;
            exh_mask      <= '0;
        end else if (enter_search) begin
            found         <= 1'b0;
            failed        <= 1'b0;
            winner_key    <= '0;
            winner_core   <= '0;
            search_cycles <= '0;
            exh_mask      <= '0;
        end else if (state_q == SEARCH) begin
            if (search_cycles != '1) search_cycles <= search_cycles + CYC_W'(1);
            exh_mask <= exh_all;
            if (take_found) begin
                found       <= 1'b1;
                winner_core <= hit_idx;
                winner_key  <= KEY_W'(key_slice(KEY_BUS_MAX_W'(cores.core_key), int'(hit_idx), KEY_W));
            end
            if (take_failed) failed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rc4_key_collector.sv
// Self-checking bench for rc4_key_collector: directed scenarios plus randomized searches,
// compared against a transaction-level reference model of the collector.
module tb_rc4_key_collector;

    localparam int LOG2 = 1;
    localparam int CC   = 2;
    localparam int KW   = 22;
    localparam int CW   = 32;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          found;
    logic          failed;
    logic [KW-1:0] winner_key;
    logic [0:0]    winner_core;
    logic [CW-1:0] search_cycles;

    rc4_key_collector_if #(.CORE_COUNT(CC), .KEY_W(KW)) bus ();

    rc4_key_collector #(
        .CORE_COUNT_LOG_2 (LOG2),
        .KEY_W            (KW),
        .CYC_W            (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .cores         (bus.slave),
        .busy          (busy),
        .found         (found),
        .failed        (failed),
        .winner_key    (winner_key),
        .winner_core   (winner_core),
        .search_cycles (search_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = idle, 1 = searching, 2 = result held.
    int            m_phase;
    bit            m_prev_start;
    bit            m_found;
    bit            m_failed;
    logic [KW-1:0] m_key;
    int            m_core;
    longint        m_cycles;
    bit [CC-1:0]   m_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance the model by one clock using the inputs presented to this edge.
    task automatic model_edge();
        if (!reset_n) begin
            m_phase = 0; m_found = 0; m_failed = 0; m_key = '0; m_core = 0;
            m_cycles = 0; m_seen = '0;
            m_prev_start = 1'b1;   // a start held through reset does not count as a rise
            return;
        end
        case (m_phase)
            0: if (start && !m_prev_start) begin
                m_phase = 1; m_found = 0; m_failed = 0; m_key = '0; m_core = 0;
                m_cycles = 0; m_seen = '0;
            end
            1: begin
                int winner;
                winner = -1;
                if (m_cycles < (64'd1 << CW) - 1) m_cycles++;
                for (int i = 0; i < CC; i++)
                    if (bus.core_found[i] && winner < 0) winner = i;
                m_seen |= bus.core_exhausted;
                if (winner >= 0) begin
                    m_phase = 2; m_found = 1; m_core = winner;
                    m_key = bus.core_key[winner*KW +: KW];
                end else if (m_seen == {CC{1'b1}}) begin
                    m_phase = 2; m_failed = 1;
                end
            end
            default: if (!start) m_phase = 0;
        endcase
        m_prev_start = start;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/busy"},     64'(busy),          64'(m_phase == 1));
        chk({tag, "/stop_all"}, 64'(bus.stop_all),  64'(m_phase == 2));
        chk({tag, "/found"},    64'(found),         64'(m_found));
        chk({tag, "/failed"},   64'(failed),        64'(m_failed));
        chk({tag, "/wkey"},     64'(winner_key),    64'(m_key));
        chk({tag, "/wcore"},    64'(winner_core),   64'(m_core));
        chk({tag, "/cycles"},   64'(search_cycles), 64'(m_cycles));
    endtask

    task automatic randomize_keys();
        for (int i = 0; i < CC; i++) bus.core_key[i*KW +: KW] = KW'($urandom);
    endtask

    // Idle core status for n cycles, checking every cycle.
    task automatic run_cycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            bus.core_found     = '0;
            bus.core_exhausted = '0;
            randomize_keys();
            tick();
            check_all(tag);
        end
    endtask

    task automatic begin_search(input string tag);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        bus.core_key       = '0;
        bus.core_found     = '0;
        bus.core_exhausted = '0;

        // 1. Reset with start held high; no search after release.
        repeat (3) tick();
        check_all("reset");
        chk("reset/busy0", 64'(busy), 64'd0);
        reset_n = 1'b1;
        run_cycles(3, "no_rise");
        chk("no_rise/busy0", 64'(busy), 64'd0);

        // 2. Core 1 finds 22'h0A3F17 on search cycle 40.
        begin_search("t2_enter");
        run_cycles(39, "t2_run");
        bus.core_found = 2'b10;
        bus.core_key[1*KW +: KW] = 22'h0A3F17;
        tick();
        check_all("t2_found");
        chk("t2/found",  64'(found),         64'd1);
        chk("t2/stop",   64'(bus.stop_all),  64'd1);
        chk("t2/wkey",   64'(winner_key),    64'h0A3F17);
        chk("t2/wcore",  64'(winner_core),   64'd1);
        chk("t2/cycles", 64'(search_cycles), 64'd40);
        run_cycles(3, "t2_hold");

        // 6. Drop start: stop released, result kept. Raise again: clean restart.
        start = 1'b0;
        tick();
        check_all("t6_drop");
        chk("t6/stop0",  64'(bus.stop_all), 64'd0);
        chk("t6/found1", 64'(found),        64'd1);
        start = 1'b1;
        tick();
        check_all("t6_restart");
        chk("t6/found0",  64'(found),         64'd0);
        chk("t6/cycles0", 64'(search_cycles), 64'd0);
        chk("t6/busy1",   64'(busy),          64'd1);

        // 3. Simultaneous finds: lowest index wins; later finds are ignored.
        run_cycles(4, "t3_run");
        bus.core_found = 2'b11;
        bus.core_key[0 +: KW]    = 22'h000100;
        bus.core_key[KW +: KW]   = 22'h000101;
        tick();
        check_all("t3_both");
        chk("t3/wcore", 64'(winner_core), 64'd0);
        chk("t3/wkey",  64'(winner_key),  64'h000100);
        bus.core_found = 2'b10;
        bus.core_key[KW +: KW] = 22'h3FFFFF;
        tick();
        check_all("t3_late");
        chk("t3/wkey_held", 64'(winner_key), 64'h000100);
        bus.core_found = '0;

        // 4. Both cores exhausted (cycles 10 and 25) -> FAILED.
        begin_search("t4_enter");
        run_cycles(9, "t4_run");
        bus.core_exhausted = 2'b01;
        tick();
        check_all("t4_exh0");
        run_cycles(14, "t4_run2");
        bus.core_exhausted = 2'b10;
        tick();
        check_all("t4_fail");
        chk("t4/failed", 64'(failed),       64'd1);
        chk("t4/found0", 64'(found),        64'd0);
        chk("t4/stop",   64'(bus.stop_all), 64'd1);
        run_cycles(2, "t4_hold");

        // 4b. Found in the same cycle as the final exhaustion -> FOUND wins.
        begin_search("t4b_enter");
        run_cycles(9, "t4b_run");
        bus.core_exhausted = 2'b01;
        tick();
        run_cycles(14, "t4b_run2");
        bus.core_exhausted = 2'b10;
        bus.core_found     = 2'b10;
        tick();
        check_all("t4b_found");
        chk("t4b/found",   64'(found),  64'd1);
        chk("t4b/failed0", 64'(failed), 64'd0);
        bus.core_found = '0;
        bus.core_exhausted = '0;

        // 5. Reset on search cycle 100, then a clean search.
        begin_search("t5_enter");
        run_cycles(99, "t5_run");
        reset_n = 1'b0;
        tick();
        check_all("t5_reset");
        chk("t5/busy0",   64'(busy),          64'd0);
        chk("t5/cycles0", 64'(search_cycles), 64'd0);
        chk("t5/stop0",   64'(bus.stop_all),  64'd0);
        reset_n = 1'b1;
        run_cycles(2, "t5_idle");
        begin_search("t5_clean");
        run_cycles(6, "t5_run2");
        bus.core_found = 2'b01;
        bus.core_key[0 +: KW] = 22'h155AA5;
        tick();
        check_all("t5_found");
        chk("t5/cycles7", 64'(search_cycles), 64'd7);
        chk("t5/wkey",    64'(winner_key),    64'h155AA5);
        bus.core_found = '0;

        // Randomized searches against the model.
        for (int it = 0; it < 16; it++) begin
            begin_search("rnd_enter");
            for (int c = 0; c < 40 && m_phase == 1; c++) begin
                randomize_keys();
                bus.core_found     = ($urandom_range(0, 9) == 0) ? CC'($urandom) : '0;
                bus.core_exhausted = ($urandom_range(0, 3) == 0) ? CC'($urandom) : '0;
                tick();
                check_all("rnd_run");
            end
            bus.core_found     = '0;
            bus.core_exhausted = '0;
            start = 1'b0;
            tick();
            check_all("rnd_drop");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
